// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator with double-buffered dividers and a small register bank.
// Optional channel phase-sync register enabled by defining CLKGEN_SYNC_EN.
module clock_enable_gen #(
    parameter int              NUM_CH        = 3,
    parameter int              DIV_WIDTH     = 8,
    parameter int              DIV_DEFAULT   = 0,
    parameter logic [5:0]      CH_EN_DEFAULT = 6'd1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [3:0]        i_addr,
    input  logic [7:0]        i_data,
    input  logic              i_we,
    input  logic              i_re,
    output logic [7:0]        o_data,
    output logic [NUM_CH-1:0] o_ce,
    output logic [NUM_CH-1:0] o_phase
);

    localparam logic [DIV_WIDTH-1:0] DIV_RST   = DIV_WIDTH'(DIV_DEFAULT);
    localparam logic [2:0]           NUM_CH_ID = 3'(NUM_CH);

    logic [NUM_CH-1:0][DIV_WIDTH-1:0] cnt_r, cnt_d_s, active_r, active_d_s, shadow_r, shadow_d_s;
    logic [NUM_CH-1:0][DIV_WIDTH-1:0] sh_lo_s, sh_hi_s;
    logic [NUM_CH-1:0][7:0]           rd_lo_s, rd_hi_s;
    logic [NUM_CH-1:0]                pending_r, pending_d_s, ce_r, ce_d_s, phase_r, phase_d_s;
    logic [NUM_CH-1:0]                ctrl_r, sync_s, wr_lo_s, wr_hi_s;
    logic [7:0]                       rdata_s, data_r;

`ifdef CLKGEN_SYNC_EN
    localparam logic SYNC_PRESENT = 1'b1;
    assign sync_s = (i_we && (i_addr == 4'hE)) ? i_data[NUM_CH-1:0] : '0;
`else
    localparam logic SYNC_PRESENT = 1'b0;
    assign sync_s = '0;
`endif

    // Phase stays high while cnt < ceil((div+1)/2).
    function automatic logic [DIV_WIDTH:0] half_f(input logic [DIV_WIDTH-1:0] a);
        half_f = ({1'b0, a} + (DIV_WIDTH+1)'(2)) >> 1'b1;
    endfunction

    // Byte-lane views of the divider registers; bits at or above DIV_WIDTH never exist.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        if (DIV_WIDTH > 8) begin : g_wide
            assign sh_lo_s[g] = {shadow_r[g][DIV_WIDTH-1:8], i_data};
            assign sh_hi_s[g] = {i_data[DIV_WIDTH-9:0], shadow_r[g][7:0]};
            assign rd_lo_s[g] = active_r[g][7:0];
            assign rd_hi_s[g] = 8'(active_r[g][DIV_WIDTH-1:8]);
        end else begin : g_narrow
            assign sh_lo_s[g] = i_data[DIV_WIDTH-1:0];
            assign sh_hi_s[g] = shadow_r[g];
            assign rd_lo_s[g] = 8'(active_r[g]);
            assign rd_hi_s[g] = 8'd0;
        end
    end

    // Divider register write decode.
    always_comb begin
        wr_lo_s = '0;
        wr_hi_s = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr_lo_s[ch] = i_we && (i_addr == 4'(2 * ch));
            wr_hi_s[ch] = i_we && (i_addr == 4'(2 * ch + 1));
        end
    end

    // Per-channel counter, divider hand-over and strobe generation.
    always_comb begin
        cnt_d_s     = cnt_r;
        active_d_s  = active_r;
        shadow_d_s  = shadow_r;
        pending_d_s = pending_r;
        ce_d_s      = '0;
        phase_d_s   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (wr_lo_s[ch]) begin
                shadow_d_s[ch] = sh_lo_s[ch];
            end else if (wr_hi_s[ch]) begin
                shadow_d_s[ch] = sh_hi_s[ch];
            end else begin
                shadow_d_s[ch] = shadow_r[ch];
            end

            if (!ctrl_r[ch]) begin
                // An idle channel has nothing to glitch, so commits apply at once.
                cnt_d_s[ch]     = '0;
                pending_d_s[ch] = 1'b0;
                if (wr_hi_s[ch]) begin
                    active_d_s[ch] = sh_hi_s[ch];
                end else if (pending_r[ch]) begin
                    active_d_s[ch] = shadow_r[ch];
                end else begin
                    active_d_s[ch] = active_r[ch];
                end
            end else if (sync_s[ch]) begin
                cnt_d_s[ch]     = '0;
                pending_d_s[ch] = 1'b0;
                active_d_s[ch]  = pending_r[ch] ? shadow_r[ch] : active_r[ch];
            end else if (cnt_r[ch] == active_r[ch]) begin
                cnt_d_s[ch] = '0;
                ce_d_s[ch]  = 1'b1;
                // A commit landing on the terminal count defers the load by one period.
                if (wr_hi_s[ch]) begin
                    pending_d_s[ch] = 1'b1;
                end else if (pending_r[ch]) begin
                    active_d_s[ch]  = shadow_r[ch];
                    pending_d_s[ch] = 1'b0;
                end else begin
                    pending_d_s[ch] = 1'b0;
                end
                phase_d_s[ch] = ({1'b0, cnt_d_s[ch]} < half_f(active_d_s[ch]));
            end else begin
                cnt_d_s[ch]     = cnt_r[ch] + DIV_WIDTH'(1);
                pending_d_s[ch] = pending_r[ch] | wr_hi_s[ch];
                phase_d_s[ch]   = ({1'b0, cnt_d_s[ch]} < half_f(active_d_s[ch]));
            end
        end
    end

    // Read mux; returns the active divider, never the shadow.
    always_comb begin
        rdata_s = 8'd0;
        case (i_addr)
            4'hC: rdata_s = 8'(ctrl_r);
            4'hD: rdata_s = 8'(pending_r);
            4'hF: rdata_s = {SYNC_PRESENT, 4'b0000, NUM_CH_ID};
            default: begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (i_addr == 4'(2 * ch)) begin
                        rdata_s = rd_lo_s[ch];
                    end else if (i_addr == 4'(2 * ch + 1)) begin
                        rdata_s = rd_hi_s[ch];
                    end else begin
                        rdata_s = rdata_s;
                    end
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_r     <= '0;
            active_r  <= {NUM_CH{DIV_RST}};
            shadow_r  <= {NUM_CH{DIV_RST}};
            pending_r <= '0;
            ce_r      <= '0;
            phase_r   <= '0;
            ctrl_r    <= CH_EN_DEFAULT[NUM_CH-1:0];
            data_r    <= 8'd0;
        end else begin
            cnt_r     <= cnt_d_s;
            active_r  <= active_d_s;
            shadow_r  <= shadow_d_s;
            pending_r <= pending_d_s;
            ce_r      <= ce_d_s;
            phase_r   <= phase_d_s;
            if (i_we && (i_addr == 4'hC)) begin
                ctrl_r <= i_data[NUM_CH-1:0];
            end else begin
                ctrl_r <= ctrl_r;
            end
            if (i_re) begin
                data_r <= rdata_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign o_ce    = ce_r;
    assign o_phase = phase_r;
    assign o_data  = data_r;

endmodule
